uart_cmd_parser: RTL and testbench
==================================

UART_CMD_PARSER -- requirements
Module: uart_cmd_parser

Interface
REQ-001 Parameter SYNC_BYTE, default 8'h55, is the frame start marker.
REQ-002 Parameter TIMEOUT_CLKS, default 40000 (1 ms at 40 MHz), is the maximum idle gap between bytes within a frame, in clocks.
REQ-003 clk40M  input  1  single clock; all logic on its rising edge.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 rx_dv  input  1  one-cycle strobe from the UART receiver: rx_byte is valid.
REQ-006 rx_byte  input  8  received byte.
REQ-007 cmdUpdate  output  1  one-cycle pulse: a complete, valid frame is on the field outputs.
REQ-008 o_cmd, o_addrLsb, o_addrMsb, o_dataLsb, o_dataMsb  output  8 each  decoded frame fields, registered.
REQ-009 frame_err  output  1  one-cycle pulse on a timeout or checksum failure.
REQ-010 err_cnt  output  8  saturating count of frame_err pulses.

Function
REQ-011 The frame SHALL be SYNC_BYTE, cmd, addrLsb, addrMsb, dataLsb, dataMsb, then a checksum byte (the checksum byte only when CHECKSUM_EN is defined).
REQ-012 The FSM SHALL have the states eIdle, eCollect, eChk and eEmit.
REQ-013 eIdle: rx_dv with rx_byte==SYNC_BYTE SHALL go to eCollect with byte index 0; any other byte SHALL be ignored, with no error raised.
REQ-014 eCollect: each rx_dv SHALL store rx_byte at the current index (0..4) and increment the index; after index 4 it SHALL go to eChk (with CHECKSUM_EN) or eEmit (without).
REQ-015 Inside eCollect, a byte equal to SYNC_BYTE SHALL be treated as data, not as a resync.
REQ-016 eChk: on rx_dv, if rx_byte equals the XOR of the 5 payload bytes, the FSM SHALL go to eEmit; otherwise it SHALL pulse frame_err and go to eIdle.
REQ-017 eEmit SHALL last exactly one cycle, drive cmdUpdate=1, and return to eIdle.
REQ-018 Field outputs SHALL be updated on the same edge that enters eEmit, so they are valid while cmdUpdate is high.
REQ-019 Field outputs SHALL hold their values until the next valid frame; a failed frame SHALL NOT modify them.
REQ-020 Latency SHALL be: final byte strobed in cycle N -> cmdUpdate high in cycle N+1.
REQ-021 A gap counter SHALL clear on entry to eCollect and on every rx_dv in eCollect/eChk, and increment on every other cycle in those states.
REQ-022 When the gap counter reaches TIMEOUT_CLKS-1 with no rx_dv, the block SHALL pulse frame_err next cycle and return to eIdle.
REQ-023 If rx_dv arrives in the same cycle the timeout is reached, the byte SHALL win and no timeout SHALL occur.
REQ-024 rx_dv during eEmit SHALL be ignored, including a SYNC_BYTE.
REQ-025 err_cnt SHALL increment by 1 per frame_err pulse and saturate at 8'hFF.
REQ-026 cmdUpdate and frame_err SHALL never be high in the same cycle.

Reset
REQ-027 When rst is high at a clock edge: state=eIdle, index=0, gap counter=0, cmdUpdate=0, frame_err=0, err_cnt=0, and all field outputs=8'h00.
REQ-028 Reset asserted mid-frame SHALL discard the partial frame, with no cmdUpdate and no frame_err.

Configuration
REQ-029 Macro CMD_PARSER_CHECKSUM_EN defined: 7-byte frames, eChk present, checksum failure handled per REQ-016.
REQ-030 Macro not defined: 6-byte frames, eChk not synthesized, eCollect goes directly to eEmit after index 4; frame_err arises from timeout only.

Verification
REQ-031 With checksum enabled, stream 55 A1 30 00 01 00 90 -> cmdUpdate for one cycle, 1 clock after the last rx_dv; o_cmd=A1, o_addrLsb=30, o_addrMsb=00, o_dataLsb=01, o_dataMsb=00; err_cnt=0.
REQ-032 Same frame with checksum byte 91 -> no cmdUpdate, one frame_err pulse, err_cnt=1, fields unchanged from the previous frame.
REQ-033 Stream 55 A1 30, then idle for TIMEOUT_CLKS clocks -> frame_err pulse and return to eIdle; a following full valid frame -> cmdUpdate.
REQ-034 Stream 00 FF 55 A1 55 00 01 00 + valid checksum -> leading bytes ignored and the embedded 55 taken as addrLsb; one cmdUpdate with o_addrLsb=55.
REQ-035 Assert rst after byte 3 of a frame, then send the remaining bytes -> no cmdUpdate, no frame_err, all outputs 00.
REQ-036 Force 300 checksum errors -> err_cnt stops at FF.

Source files
------------

// File: rtl/uart_cmd_parser.sv
// UART command frame parser: SYNC, cmd, addrLsb, addrMsb, dataLsb, dataMsb[, checksum].
// Define CMD_PARSER_CHECKSUM_EN to require a trailing XOR checksum byte (7-byte frames).
module uart_cmd_parser #(
    parameter logic [7:0]  SYNC_BYTE    = 8'h55,
    parameter int unsigned TIMEOUT_CLKS = 40000
) (
    input  logic       clk40M,
    input  logic       rst,
    input  logic       rx_dv,
    input  logic [7:0] rx_byte,
    output logic       cmdUpdate,
    output logic [7:0] o_cmd,
    output logic [7:0] o_addrLsb,
    output logic [7:0] o_addrMsb,
    output logic [7:0] o_dataLsb,
    output logic [7:0] o_dataMsb,
    output logic       frame_err,
    output logic [7:0] err_cnt
);

    localparam int unsigned GAP_W = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;
    localparam logic [GAP_W-1:0] GAP_MAX = GAP_W'(TIMEOUT_CLKS - 1);
`ifdef CMD_PARSER_CHECKSUM_EN
    localparam int unsigned NBUF = 5;
`else
    localparam int unsigned NBUF = 4;
`endif

    typedef enum logic [1:0] {eIdle, eCollect, eChk, eEmit} state_t;

    state_t                     state;
    logic [2:0]                 idx;
    logic [GAP_W-1:0]           gap;
    logic [NBUF-1:0][7:0]       pay;   // shift register, oldest byte in the top slot

    always_ff @(posedge clk40M) begin
        if (rst) begin
            state     <= eIdle;
            idx       <= '0;
            gap       <= '0;
            pay       <= '0;
            cmdUpdate <= 1'b0;
            frame_err <= 1'b0;
            o_cmd     <= 8'h00;
            o_addrLsb <= 8'h00;
            o_addrMsb <= 8'h00;
            o_dataLsb <= 8'h00;
            o_dataMsb <= 8'h00;
        end else begin
            cmdUpdate <= 1'b0;
            frame_err <= 1'b0;
            case (state)
                eIdle: begin
                    if (rx_dv && rx_byte == SYNC_BYTE) begin
                        state <= eCollect;
                        idx   <= '0;
                        gap   <= '0;
                    end
                end
                eCollect: begin
                    if (rx_dv) begin
                        pay <= {pay[NBUF-2:0], rx_byte};
                        idx <= idx + 3'd1;
                        gap <= '0;
                        if (idx == 3'd4) begin
`ifdef CMD_PARSER_CHECKSUM_EN
                            state     <= eChk;
`else
                            state     <= eEmit;
                            cmdUpdate <= 1'b1;
                            o_cmd     <= pay[3];
                            o_addrLsb <= pay[2];
                            o_addrMsb <= pay[1];
                            o_dataLsb <= pay[0];
                            o_dataMsb <= rx_byte;
`endif
                        end
                    end else if (gap == GAP_MAX) begin
                        state     <= eIdle;
                        idx       <= '0;
                        frame_err <= 1'b1;
                    end else begin
                        gap <= gap + GAP_W'(1);
                    end
                end
`ifdef CMD_PARSER_CHECKSUM_EN
                eChk: begin
                    if (rx_dv) begin
                        gap <= '0;
                        idx <= '0;
                        if (rx_byte == (pay[4] ^ pay[3] ^ pay[2] ^ pay[1] ^ pay[0])) begin
                            state     <= eEmit;
                            cmdUpdate <= 1'b1;
                            o_cmd     <= pay[4];
                            o_addrLsb <= pay[3];
                            o_addrMsb <= pay[2];
                            o_dataLsb <= pay[1];
                            o_dataMsb <= pay[0];
                        end else begin
                            state     <= eIdle;
                            frame_err <= 1'b1;
                        end
                    end else if (gap == GAP_MAX) begin
                        state     <= eIdle;
                        idx       <= '0;
                        frame_err <= 1'b1;
                    end else begin
                        gap <= gap + GAP_W'(1);
                    end
                end
`endif
                eEmit: begin
                    // bytes arriving here, including SYNC_BYTE, are dropped
                    state <= eIdle;
                    idx   <= '0;
                    gap   <= '0;
                end
                default: begin
                    state <= eIdle;
                end
            endcase
        end
    end

    // Saturating error counter, lags the frame_err pulse by one cycle
    always_ff @(posedge clk40M) begin
        if (rst) begin
            err_cnt <= 8'h00;
        end else if (frame_err && err_cnt != 8'hFF) begin
            err_cnt <= err_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Directed bench for uart_cmd_parser; follows CMD_PARSER_CHECKSUM_EN like the design.
module tb_uart_cmd_parser;

    localparam int unsigned TMO = 16;
`ifdef CMD_PARSER_CHECKSUM_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       rx_dv;
    logic [7:0] rx_byte;
    logic       cmdUpdate;
    logic [7:0] o_cmd, o_addrLsb, o_addrMsb, o_dataLsb, o_dataMsb;
    logic       frame_err;
    logic [7:0] err_cnt;

    uart_cmd_parser #(.SYNC_BYTE(8'h55), .TIMEOUT_CLKS(TMO)) dut (
        .clk40M   (clk),
        .rst      (rst),
        .rx_dv    (rx_dv),
        .rx_byte  (rx_byte),
        .cmdUpdate(cmdUpdate),
        .o_cmd    (o_cmd),
        .o_addrLsb(o_addrLsb),
        .o_addrMsb(o_addrMsb),
        .o_dataLsb(o_dataLsb),
        .o_dataMsb(o_dataMsb),
        .frame_err(frame_err),
        .err_cnt  (err_cnt)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cu_cnt = 0;
    int fe_cnt = 0;
    int overlap = 0;

    always @(negedge clk) begin
        if (cmdUpdate) cu_cnt++;
        if (frame_err) fe_cnt++;
        if (cmdUpdate && frame_err) overlap++;
    end

    typedef struct {
        logic [39:0] pay;
        logic [7:0]  chk;
        logic        exp_upd;
        logic        exp_err;
        logic [39:0] exp_f;
    } vec_t;

    vec_t vecs[6];

    function automatic logic [39:0] fields();
        return {o_cmd, o_addrLsb, o_addrMsb, o_dataLsb, o_dataMsb};
    endfunction

    task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    // caller sits just after a rising edge; byte is captured on the next one
    task automatic send_byte(input logic [7:0] b);
        rx_dv   = 1'b1;
        rx_byte = b;
        @(posedge clk);
        #1;
        rx_dv   = 1'b0;
        rx_byte = 8'h00;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [39:0] p, input logic [7:0] c);
        send_byte(8'h55);
        send_byte(p[39:32]);
        send_byte(p[31:24]);
        send_byte(p[23:16]);
        send_byte(p[15:8]);
        send_byte(p[7:0]);
        if (CHK) send_byte(c);
    endtask

    int cu0, fe0;

    initial begin
        rst = 1'b1; rx_dv = 1'b0; rx_byte = 8'h00;
        vecs[0] = '{40'h12_34_56_78_9A, 8'h92, 1'b1, 1'b0, 40'h12_34_56_78_9A};
        vecs[1] = '{40'hA1_30_00_01_00, 8'h90, 1'b1, 1'b0, 40'hA1_30_00_01_00};
        vecs[2] = '{40'hA1_30_00_01_00, 8'h91, 1'b0, 1'b1, 40'hA1_30_00_01_00};
        vecs[3] = '{40'hFF_EE_DD_CC_BB, 8'h00, 1'b0, 1'b1, 40'hA1_30_00_01_00};
        vecs[4] = '{40'h55_55_55_55_55, 8'h55, 1'b1, 1'b0, 40'h55_55_55_55_55};
        vecs[5] = '{40'h00_FF_00_FF_00, 8'h00, 1'b1, 1'b0, 40'h00_FF_00_FF_00};

        repeat (3) @(posedge clk);
        #1;
        check("reset_fields", fields(), 40'h0);
        check("reset_upd", 40'(cmdUpdate), 40'h0);
        check("reset_err", 40'(frame_err), 40'h0);
        check("reset_errcnt", 40'(err_cnt), 40'h0);
        rst = 1'b0;
        idle(1);

        // table: pulse on the cycle after the last byte, gone one cycle later
        for (int i = 0; i < 6; i++) begin
            if (!CHK && !vecs[i].exp_upd) continue;
            send_frame(vecs[i].pay, vecs[i].chk);
            check($sformatf("row%0d_upd", i), 40'(cmdUpdate), 40'(vecs[i].exp_upd));
            check($sformatf("row%0d_err", i), 40'(frame_err), 40'(vecs[i].exp_err));
            check($sformatf("row%0d_fields", i), fields(), vecs[i].exp_f);
            idle(1);
            check($sformatf("row%0d_upd_off", i), 40'(cmdUpdate), 40'h0);
            check($sformatf("row%0d_err_off", i), 40'(frame_err), 40'h0);
        end
        idle(1);
        check("table_errcnt", 40'(err_cnt), CHK ? 40'd2 : 40'd0);

        // timeout: idle TMO clocks after a byte
        send_byte(8'h55); send_byte(8'hA1); send_byte(8'h30);
        idle(TMO - 1);
        check("tmo_early", 40'(frame_err), 40'h0);
        idle(1);
        check("tmo_pulse", 40'(frame_err), 40'h1);
        idle(1);
        check("tmo_pulse_off", 40'(frame_err), 40'h0);
        check("tmo_errcnt", 40'(err_cnt), CHK ? 40'd3 : 40'd1);
        send_frame(40'h12_34_56_78_9A, 8'h92);
        check("tmo_recover_upd", 40'(cmdUpdate), 40'h1);
        check("tmo_recover_f", fields(), 40'h12_34_56_78_9A);
        idle(1);

        // byte arriving exactly at the timeout boundary wins
        send_byte(8'h55); send_byte(8'hA1);
        idle(TMO - 1);
        send_byte(8'h30);
        check("edge_no_err", 40'(frame_err), 40'h0);
        send_byte(8'h00); send_byte(8'h01); send_byte(8'h00);
        if (CHK) send_byte(8'h90);
        check("edge_upd", 40'(cmdUpdate), 40'h1);
        check("edge_fields", fields(), 40'hA1_30_00_01_00);
        idle(1);

        // junk ahead of SYNC ignored, embedded 55 is addrLsb
        cu0 = cu_cnt; fe0 = fe_cnt;
        send_byte(8'h00); send_byte(8'hFF);
        send_frame(40'hA1_55_00_01_00, 8'hF5);
        check("resync_upd", 40'(cmdUpdate), 40'h1);
        check("resync_addrlsb", 40'(o_addrLsb), 40'h55);
        idle(1);
        check("resync_one_upd", 40'(cu_cnt - cu0), 40'd1);
        check("resync_no_err", 40'(fe_cnt - fe0), 40'd0);

        // SYNC during eEmit dropped, trailing bytes fall on eIdle
        cu0 = cu_cnt; fe0 = fe_cnt;
        send_frame(40'h12_34_56_78_9A, 8'h92);
        send_byte(8'h55);
        send_byte(8'hA1); send_byte(8'h30); send_byte(8'h00);
        send_byte(8'h01); send_byte(8'h00);
        if (CHK) send_byte(8'h90);
        idle(TMO + 4);
        check("emit_ignore_upd", 40'(cu_cnt - cu0), 40'd1);
        check("emit_ignore_err", 40'(fe_cnt - fe0), 40'd0);
        check("emit_ignore_f", fields(), 40'h12_34_56_78_9A);

        // reset mid-frame discards the partial frame
        cu0 = cu_cnt; fe0 = fe_cnt;
        send_byte(8'h55); send_byte(8'hA1); send_byte(8'h30);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        send_byte(8'h00); send_byte(8'h01); send_byte(8'h00);
        if (CHK) send_byte(8'h90);
        idle(TMO + 4);
        check("midrst_upd", 40'(cu_cnt - cu0), 40'd0);
        check("midrst_err", 40'(fe_cnt - fe0), 40'd0);
        check("midrst_fields", fields(), 40'h0);
        check("midrst_errcnt", 40'(err_cnt), 40'h0);

        // 300 errors saturate err_cnt
        for (int i = 0; i < 300; i++) begin
            if (CHK) begin
                send_frame(40'h0, 8'h01);
            end else begin
                send_byte(8'h55);
                idle(TMO);
            end
            idle(2);
            if (i == 253) check("sat_fe", 40'(err_cnt), 40'hFE);
            if (i == 254) check("sat_ff", 40'(err_cnt), 40'hFF);
        end
        check("sat_hold", 40'(err_cnt), 40'hFF);
        check("sat_fields", fields(), 40'h0);
        check("no_overlap", 40'(overlap), 40'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
